// File: rtl/vault_lock_if.sv
// Keypad/display bundle for the vault lock: asynchronous keypad inputs in, status and segments out.
interface vault_lock_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       prog_en;
  logic       unlocked;
  logic       lockout;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [6:0] HEX4;
  logic [6:0] HEX5;

  // Keypad/switch side drives the inputs and observes the outputs.
  modport master (
    output key_valid, key_code, prog_en,
    input  unlocked, lockout, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );

  // Lock controller side.
  modport slave (
    input  key_valid, key_code, prog_en,
    output unlocked, lockout, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
endinterface

// File: rtl/vault_lock.sv
// Keypad vault controller: synchronised key entry, code compare, lockout,
// in-field reprogramming and per-digit feedback on six seven-segment displays.
module vault_lock #(
  parameter int unsigned DIGITS         = 6,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 250_000_000,
  parameter logic [23:0] DEFAULT_CODE   = 24'h123456,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input logic          MAX10_CLK1_50,
  input logic          reset_n,
  vault_lock_if.slave  bus
);

  localparam int unsigned BW = DIGITS * 4;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned FW = 4;
  localparam int unsigned TW = $clog2(LOCKOUT_CYCLES);

  localparam logic [3:0] KEY_ENTER  = 4'hE;
  localparam logic [3:0] KEY_CANCEL = 4'hF;

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Fixed banners, HEX5 in the top bits down to HEX0 in the bottom bits.
  localparam logic [41:0] PAT_LOCKED = {7'h47, 7'h40, 7'h46, 7'h09, 7'h06, 7'h40};
  localparam logic [41:0] PAT_OPEN   = {7'h77, 7'h40, 7'h0C, 7'h06, 7'h2B, 7'h77};

  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_ENTRY,
    ST_OPEN,
    ST_PROGRAM,
    ST_LOCKOUT
  } state_t;

  // Standard active-low hex font, {g..a}.
  function automatic logic [6:0] hex_font(input logic [3:0] d);
    logic [6:0] seg;
    case (d)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  logic [SYNC_STAGES-1:0] r_kv_sync;
  logic [SYNC_STAGES-1:0] r_pe_sync;
  logic [3:0]             r_kc_sync [SYNC_STAGES];
  logic                   r_kv_prev;

  state_t          r_state;
  logic [BW-1:0]   r_buf;
  logic [BW-1:0]   r_code;
  logic [CW-1:0]   r_cnt;
  logic [FW-1:0]   r_fail;
  logic [TW-1:0]   r_timer;
  logic            r_unlocked;
  logic            r_lockout;
  logic [6:0]      r_hex [6];

  logic            w_kv;
  logic            w_pe;
  logic [3:0]      w_kc;
  logic            w_evt;
  logic            w_is_digit;
  logic [BW-1:0]   w_shift;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_full;
  logic [FW-1:0]   w_fail_inc;

  state_t          w_nx_state;
  logic [BW-1:0]   w_nx_buf;
  logic [BW-1:0]   w_nx_code;
  logic [CW-1:0]   w_nx_cnt;
  logic [FW-1:0]   w_nx_fail;
  logic [TW-1:0]   w_nx_timer;
  logic [23:0]     w_nx_buf24;
  logic [6:0]      w_nx_hex [6];

  // Synchroniser chains for the asynchronous keypad and program switch, plus edge history.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_kv_sync <= '0;
      r_pe_sync <= '0;
      r_kv_prev <= 1'b0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        r_kc_sync[i] <= 4'h0;
      end
    end else begin
      r_kv_sync    <= {r_kv_sync[SYNC_STAGES-2:0], bus.key_valid};
      r_pe_sync    <= {r_pe_sync[SYNC_STAGES-2:0], bus.prog_en};
      r_kv_prev    <= w_kv;
      r_kc_sync[0] <= bus.key_code;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        r_kc_sync[i] <= r_kc_sync[i-1];
      end
    end
  end

  assign w_kv       = r_kv_sync[SYNC_STAGES-1];
  assign w_pe       = r_pe_sync[SYNC_STAGES-1];
  assign w_kc       = r_kc_sync[SYNC_STAGES-1];
  assign w_evt      = w_kv & ~r_kv_prev;
  assign w_is_digit = (w_kc != KEY_ENTER) && (w_kc != KEY_CANCEL);
  assign w_full     = (r_cnt == CW'(DIGITS));
  assign w_cnt_inc  = w_full ? r_cnt : r_cnt + CW'(1);
  assign w_fail_inc = r_fail + FW'(1);

  // Entry buffer shift: newest digit at [3:0], oldest drops off the top.
  if (DIGITS == 1) begin : g_shift_one
    assign w_shift = w_kc;
  end else begin : g_shift_many
    assign w_shift = {r_buf[BW-5:0], w_kc};
  end

  // Next-state decode for the lock FSM and its datapath.
  always_comb begin
    w_nx_state = r_state;
    w_nx_buf   = r_buf;
    w_nx_code  = r_code;
    w_nx_cnt   = r_cnt;
    w_nx_fail  = r_fail;
    w_nx_timer = r_timer;
    case (r_state)
      ST_LOCKED: begin
        if (w_evt && w_is_digit) begin
          w_nx_buf   = BW'(w_kc);
          w_nx_cnt   = CW'(1);
          w_nx_state = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (w_evt) begin
          if (w_is_digit) begin
            w_nx_buf = w_shift;
            w_nx_cnt = w_cnt_inc;
          end else if (w_kc == KEY_CANCEL) begin
            w_nx_buf   = '0;
            w_nx_cnt   = '0;
            w_nx_state = ST_LOCKED;
          end else begin
            w_nx_buf = '0;
            w_nx_cnt = '0;
            if (w_full && (r_buf == r_code)) begin
              w_nx_fail  = '0;
              w_nx_state = ST_OPEN;
            end else begin
              w_nx_fail = w_fail_inc;
              if (w_fail_inc >= FW'(MAX_FAILS)) begin
                w_nx_timer = TW'(LOCKOUT_CYCLES - 1);
                w_nx_state = ST_LOCKOUT;
              end else begin
                w_nx_state = ST_LOCKED;
              end
            end
          end
        end
      end
      ST_OPEN: begin
        if (w_evt) begin
          if (w_kc == KEY_CANCEL) begin
            w_nx_state = ST_LOCKED;
          end else if (w_is_digit && w_pe) begin
            w_nx_buf   = BW'(w_kc);
            w_nx_cnt   = CW'(1);
            w_nx_state = ST_PROGRAM;
          end
        end
      end
      ST_PROGRAM: begin
        // Dropping the program switch wins over any key on the same cycle.
        if (!w_pe) begin
          w_nx_buf   = '0;
          w_nx_cnt   = '0;
          w_nx_state = ST_OPEN;
        end else if (w_evt) begin
          if (w_is_digit) begin
            w_nx_buf = w_shift;
            w_nx_cnt = w_cnt_inc;
          end else begin
            if ((w_kc == KEY_ENTER) && w_full) begin
              w_nx_code = r_buf;
            end
            w_nx_buf   = '0;
            w_nx_cnt   = '0;
            w_nx_state = ST_OPEN;
          end
        end
      end
      ST_LOCKOUT: begin
        if (r_timer == '0) begin
          w_nx_fail  = '0;
          w_nx_state = ST_LOCKED;
        end else begin
          w_nx_timer = r_timer - TW'(1);
        end
      end
      default: begin
        w_nx_state = ST_LOCKED;
      end
    endcase
  end

  assign w_nx_buf24 = 24'(w_nx_buf);

  // Display contents for the state being entered, so the segments register alongside it.
  always_comb begin
    for (int unsigned i = 0; i < 6; i++) begin
      w_nx_hex[i] = SEG_BLANK;
      case (w_nx_state)
        ST_LOCKED:  w_nx_hex[i] = PAT_LOCKED[7*i +: 7];
        ST_OPEN:    w_nx_hex[i] = PAT_OPEN[7*i +: 7];
        ST_LOCKOUT: w_nx_hex[i] = SEG_DASH;
        ST_ENTRY: begin
          if ((i < DIGITS) && (i < 32'(w_nx_cnt))) begin
            w_nx_hex[i] = SEG_DASH;
          end
        end
        ST_PROGRAM: begin
          if ((i < DIGITS) && (i < 32'(w_nx_cnt))) begin
            w_nx_hex[i] = hex_font(w_nx_buf24[4*i +: 4]);
          end
        end
        default: w_nx_hex[i] = SEG_BLANK;
      endcase
    end
  end

  // Lock FSM state, datapath and registered outputs.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_LOCKED;
      r_buf      <= '0;
      r_code     <= BW'(DEFAULT_CODE);
      r_cnt      <= '0;
      r_fail     <= '0;
      r_timer    <= '0;
      r_unlocked <= 1'b0;
      r_lockout  <= 1'b0;
      for (int unsigned i = 0; i < 6; i++) begin
        r_hex[i] <= PAT_LOCKED[7*i +: 7];
      end
    end else begin
      r_state    <= w_nx_state;
      r_buf      <= w_nx_buf;
      r_code     <= w_nx_code;
      r_cnt      <= w_nx_cnt;
      r_fail     <= w_nx_fail;
      r_timer    <= w_nx_timer;
      r_unlocked <= (w_nx_state == ST_OPEN) || (w_nx_state == ST_PROGRAM);
      r_lockout  <= (w_nx_state == ST_LOCKOUT);
      for (int unsigned i = 0; i < 6; i++) begin
        r_hex[i] <= w_nx_hex[i];
      end
    end
  end

  assign bus.unlocked = r_unlocked;
  assign bus.lockout  = r_lockout;
  assign bus.HEX0     = r_hex[0];
  assign bus.HEX1     = r_hex[1];
  assign bus.HEX2     = r_hex[2];
  assign bus.HEX3     = r_hex[3];
  assign bus.HEX4     = r_hex[4];
  assign bus.HEX5     = r_hex[5];

endmodule

// File: tb/tb_vault_lock.sv
// Bench for vault_lock: directed scenarios plus random keys against a queue-based model of the lock.
module tb_vault_lock;

  logic clk;
  logic rst_n;

  vault_lock_if bus ();

  vault_lock #(
    .DIGITS        (4),
    .MAX_FAILS     (3),
    .LOCKOUT_CYCLES(100),
    .DEFAULT_CODE  (24'h001234),
    .SYNC_STAGES   (2)
  ) dut (
    .MAX10_CLK1_50(clk),
    .reset_n      (rst_n),
    .bus          (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {M_LOCKED, M_ENTRY, M_OPEN, M_PROG, M_LOCKOUT} mstate_t;

  logic [6:0] PAT_L [6] = '{7'h40, 7'h06, 7'h09, 7'h46, 7'h40, 7'h47};
  logic [6:0] PAT_O [6] = '{7'h77, 7'h2B, 7'h06, 7'h0C, 7'h40, 7'h77};
  logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  mstate_t     m_state;
  int          m_q[$];
  logic [15:0] m_code;
  int          m_fail;
  bit          m_pe;
  bit          m_valid;

  int n_checks;
  int n_err;
  int run_len;
  int last_run;

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] q_val();
    logic [15:0] v = 16'h0;
    foreach (m_q[i]) v = {v[11:0], 4'(m_q[i])};
    return v;
  endfunction

  function automatic void model_reset();
    m_state = M_LOCKED;
    m_q.delete();
    m_code  = 16'h1234;
    m_fail  = 0;
  endfunction

  // Abstract effect of one key event on the lock.
  function automatic void model_key(input int k);
    bit dig = (k <= 13);
    case (m_state)
      M_LOCKED: if (dig) begin m_q.delete(); m_q.push_back(k); m_state = M_ENTRY; end
      M_ENTRY: begin
        if (dig) begin
          m_q.push_back(k);
          if (m_q.size() > 4) void'(m_q.pop_front());
        end else if (k == 15) begin
          m_q.delete(); m_state = M_LOCKED;
        end else begin
          if (m_q.size() == 4 && q_val() == m_code) begin
            m_fail = 0; m_state = M_OPEN;
          end else begin
            m_fail++;
            m_state = (m_fail >= 3) ? M_LOCKOUT : M_LOCKED;
          end
          m_q.delete();
        end
      end
      M_OPEN: begin
        if (k == 15) m_state = M_LOCKED;
        else if (dig && m_pe) begin m_q.delete(); m_q.push_back(k); m_state = M_PROG; end
      end
      M_PROG: begin
        if (dig) begin
          m_q.push_back(k);
          if (m_q.size() > 4) void'(m_q.pop_front());
        end else begin
          if (k == 14 && m_q.size() == 4) m_code = q_val();
          m_q.delete(); m_state = M_OPEN;
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [43:0] exp_out();
    logic [6:0] h [6];
    int n = m_q.size();
    for (int i = 0; i < 6; i++) begin
      case (m_state)
        M_LOCKED:  h[i] = PAT_L[i];
        M_OPEN:    h[i] = PAT_O[i];
        M_LOCKOUT: h[i] = 7'h3F;
        M_ENTRY:   h[i] = (i < n) ? 7'h3F : 7'h7F;
        default:   h[i] = (i < n) ? FONT[m_q[n-1-i]] : 7'h7F;
      endcase
    end
    return {(m_state == M_OPEN || m_state == M_PROG), (m_state == M_LOCKOUT),
            h[5], h[4], h[3], h[2], h[1], h[0]};
  endfunction

  function automatic logic [43:0] act_out();
    return {bus.unlocked, bus.lockout, bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
  endfunction

  // Per-cycle comparison against the model whenever the outputs have settled.
  always @(posedge clk) begin
    #1;
    if (m_valid && rst_n) check("cycle", act_out(), exp_out());
  end

  // Length of each lockout pulse in clocks.
  always @(posedge clk) begin
    #1;
    if (!rst_n) run_len = 0;
    else if (bus.lockout === 1'b1) run_len++;
    else if (run_len > 0) begin last_run = run_len; run_len = 0; end
  end

  task automatic press(input int k);
    m_valid = 0;
    bus.key_code  = 4'(k);
    bus.key_valid = 1'b1;
    repeat (5) @(negedge clk);
    model_key(k);
    m_valid = 1;
    bus.key_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_pe(input bit v);
    m_valid = 0;
    bus.prog_en = v;
    repeat (5) @(negedge clk);
    m_pe = v;
    if (m_state == M_PROG && !v) begin m_q.delete(); m_state = M_OPEN; end
    m_valid = 1;
  endtask

  task automatic type_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(int'(c[4*i +: 4]));
    press(14);
  endtask

  task automatic wait_lockout_end();
    int n = 0;
    m_valid = 0;
    while (bus.lockout === 1'b1 && n < 300) begin @(negedge clk); n++; end
    check("lockout_timeout", 44'(n < 300), 44'(1));
    m_state = M_LOCKED; m_fail = 0; m_q.delete();
    @(negedge clk);
    m_valid = 1;
    check("lockout_len", 44'(last_run), 44'(100));
  endtask

  task automatic do_reset();
    m_valid = 0;
    rst_n = 1'b0;
    #1;
    check("reset_hex", 44'({bus.HEX5, bus.HEX4, bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0}),
          44'({7'h47, 7'h40, 7'h46, 7'h09, 7'h06, 7'h40}));
    check("reset_unlocked", 44'(bus.unlocked), 44'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    m_valid = 1;
  endtask

  initial begin
    n_checks = 0; n_err = 0; run_len = 0; last_run = 0;
    m_valid = 0; m_pe = 0;
    model_reset();
    rst_n = 1'b0;
    bus.key_valid = 1'b0; bus.key_code = 4'h0; bus.prog_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("por_hex0", 44'(bus.HEX0), 44'(7'h40));
    check("por_hex5", 44'(bus.HEX5), 44'(7'h47));
    check("por_status", 44'({bus.unlocked, bus.lockout}), 44'(0));
    m_valid = 1;

    // Basic unlock with per-digit dash fill.
    press(1);
    check("entry1", 44'({bus.HEX1, bus.HEX0}), 44'({7'h7F, 7'h3F}));
    press(2);
    check("entry2", 44'({bus.HEX2, bus.HEX1}), 44'({7'h7F, 7'h3F}));
    press(3); press(4);
    check("entry4", 44'({bus.HEX5, bus.HEX4, bus.HEX3}), 44'({7'h7F, 7'h7F, 7'h3F}));
    press(14);
    check("open_unlocked", 44'(bus.unlocked), 44'(1));
    check("open_hex0", 44'(bus.HEX0), 44'(7'h77));
    press(15);

    // Overflow drops the oldest digit; short entry fails.
    press(9); type_code(16'h1234);
    check("overflow_open", 44'(bus.unlocked), 44'(1));
    press(15);
    press(1); press(2); press(3); press(14);
    check("short_fail", 44'({bus.unlocked, bus.HEX5}), 44'({1'b0, 7'h47}));

    // Failures persist across entries, third one locks out.
    press(1); press(1); press(14);
    press(2); press(2); press(14);
    check("lockout_on", 44'({bus.lockout, bus.HEX0}), 44'({1'b1, 7'h3F}));
    press(5); press(14);
    wait_lockout_end();
    press(1); press(2); press(3); press(14);
    type_code(16'h1234);
    check("fail_cleared", 44'(bus.unlocked), 44'(1));

    // Programming a new code.
    set_pe(1);
    press(10);
    check("prog_digit", 44'({bus.HEX1, bus.HEX0}), 44'({7'h7F, 7'h08}));
    press(11); press(12); press(13);
    check("prog_full", 44'({bus.HEX3, bus.HEX0}), 44'({7'h08, 7'h21}));
    press(14);
    press(15);
    type_code(16'h1234);
    check("old_code_rejected", 44'(bus.unlocked), 44'(0));
    type_code(16'hABCD);
    check("new_code_ok", 44'(bus.unlocked), 44'(1));

    // Short program entry and switch drop leave the code alone.
    do_reset();
    type_code(16'h1234);
    press(5); press(6); press(14);
    press(15);
    type_code(16'h1234);
    check("short_prog_kept", 44'(bus.unlocked), 44'(1));
    press(5); press(6); press(7);
    set_pe(0);
    check("pe_drop_open", 44'({bus.unlocked, bus.HEX0}), 44'({1'b1, 7'h77}));
    set_pe(1);

    // prog_en drop coincident with enter: the drop wins.
    press(8); press(8); press(8); press(8);
    m_valid = 0;
    bus.prog_en = 1'b0; bus.key_code = 4'hE; bus.key_valid = 1'b1;
    repeat (5) @(negedge clk);
    m_pe = 0; m_q.delete(); m_state = M_OPEN;
    m_valid = 1;
    bus.key_valid = 1'b0;
    repeat (4) @(negedge clk);
    press(15);
    type_code(16'h1234);
    check("simul_drop_kept", 44'(bus.unlocked), 44'(1));

    // Reset in the middle of programming.
    set_pe(1);
    press(7); press(7);
    do_reset();
    type_code(16'h1234);
    check("after_reset_open", 44'(bus.unlocked), 44'(1));

    // Random traffic.
    for (int it = 0; it < 250; it++) begin
      int r = int'($urandom_range(0, 99));
      if (r < 6) begin
        set_pe(!m_pe);
      end else if (r < 18) begin
        type_code(m_code);
      end else begin
        int r2 = int'($urandom_range(0, 99));
        press(r2 < 70 ? int'($urandom_range(0, 13)) : (r2 < 85 ? 14 : 15));
      end
      if (m_state == M_LOCKOUT) begin
        press(int'($urandom_range(0, 15)));
        wait_lockout_end();
      end
    end

    m_valid = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/vault_lock.md
# vault_lock

Parametrised keypad vault controller for the DE10-Lite lock build. It synchronises asynchronous keypad events and collects a DIGITS-long hexadecimal code. On `#` it compares the code against a stored password, using an explicit state machine. It adds failed-attempt lockout, in-field password programming and per-digit entry feedback on the six seven-segment displays.

## Interface
- DIGITS, 6: password length in hex digits, 1..6.
- MAX_FAILS, 3: consecutive wrong attempts that trigger lockout, 1..15.
- LOCKOUT_CYCLES, 250_000_000: lockout duration in clocks (5 s at 50 MHz), ≥ 2.
- DEFAULT_CODE, 24'h123456: password after reset; low DIGITS*4 bits used, newest digit in [3:0].
- SYNC_STAGES, 2: synchroniser depth, ≥ 2.

Ports:
- MAX10_CLK1_50  in  1  system clock; one clock domain.
- reset_n  in  1  reset, asynchronous, active-low.
- key_valid  in  1  asynchronous keypad strobe; high while a key is held.
- key_code  in  4  asynchronous key value; stable whenever key_valid is high.
- prog_en  in  1  asynchronous program-mode switch.
- unlocked  out  1  high in OPEN and PROGRAM.
- lockout  out  1  high in LOCKOUT.
- HEX0..HEX5  out  7 each  active-low segments {g..a}; HEX0 is rightmost.

## Operation
- key_valid, key_code and prog_en each pass through SYNC_STAGES flops.
- A rising edge of synced key_valid is one key event. key_code is sampled that cycle. Holding the key produces no repeats.
- Key map:
  - 0x0–0xD are digits.
  - 0xE is `#` (enter).
  - 0xF is `*` (cancel).
- Entry buffer: DIGITS×4 bits, shifting left. The new digit enters at [3:0]. Once full, the oldest digit falls out. count saturates at DIGITS.
- States:
  - **LOCKED**: digit → load buffer, count=1, go to ENTRY. `#` and `*` are ignored.
  - **ENTRY**:
    - digit → shift.
    - `*` → clear buffer and count, go to LOCKED.
    - `#` with count==DIGITS and buffer==code → OPEN, fail_cnt=0.
    - Any other `#` → fail_cnt+1, clear buffer; go to LOCKOUT if fail_cnt reaches MAX_FAILS (timer loaded), else LOCKED.
  - **OPEN**:
    - `*` → LOCKED.
    - digit with prog_en high → PROGRAM with that digit loaded, count=1.
    - digit with prog_en low → ignored.
  - **PROGRAM**:
    - digit → shift.
    - `#` with count==DIGITS → code=buffer, go to OPEN.
    - `#` with count<DIGITS, `*`, or prog_en low → discard buffer, go to OPEN.
  - **LOCKOUT**: all keys ignored. The timer counts down LOCKOUT_CYCLES, then the block goes to LOCKED with fail_cnt=0.
- Display, as active-low 7-bit codes for HEX5..HEX0:
  - LOCKED: 47,40,46,09,06,40.
  - OPEN: 77,40,0C,06,2B,77.
  - LOCKOUT: all 3F (dash).
  - ENTRY: the rightmost count displays show dash (3F); all others are blank (7F).
  - PROGRAM: the rightmost count displays show the actual digits in standard hex font; all others are blank.
  - Displays above DIGITS-1 are always blank in ENTRY and PROGRAM.
- The stored code lives in flops only and returns to DEFAULT_CODE on reset.

## Timing
- Reset (async assert, sync release) sets:
  - state LOCKED, code=DEFAULT_CODE;
  - buffer, count, fail_cnt and timer = 0;
  - unlocked=0, lockout=0;
  - HEX = LOCKED pattern.
- All outputs are registered.
- Latency: a pin edge sampled at clock k becomes a synced edge at k+SYNC_STAGES. State and outputs update at k+SYNC_STAGES+1.
- Minimum key pitch is 2 clocks low plus 2 clocks high after sync. Faster toggling is unsupported.
- Simultaneous prog_en deassert and `#` in PROGRAM: the deassert wins and the code is unchanged.
- Lockout: lockout rises on the cycle the failing `#` is processed. It is high for exactly LOCKOUT_CYCLES clocks, and state is LOCKED on the following clock.
- fail_cnt persists across LOCKED↔ENTRY. Only a success, lockout expiry or reset clears it.
- Reset mid-operation aborts with no partial code write.

## Test plan
Parameters for all scenarios: DIGITS=4, DEFAULT_CODE=24'h001234, MAX_FAILS=3, LOCKOUT_CYCLES=100.
- Reset, then keys 1,2,3,4,`#` → unlocked=1 and HEX shows the OPEN pattern. During entry HEX3..HEX0 fill with 3F, one per key, from HEX0 upward.
- Keys 9,1,2,3,4,`#` (overflow drops the 9) → unlocked=1. Keys 1,2,3,`#` → LOCKED, fail_cnt=1.
- Three wrong entries → lockout=1 for exactly 100 clocks with all HEX=3F. Keys during lockout are ignored. Then LOCKED with fail_cnt=0.
- Unlock, set prog_en=1, keys A,B,C,D,`#` → OPEN. Then `*` → LOCKED. Keys 1,2,3,4,`#` fails. Keys A,B,C,D,`#` → OPEN.
- Unlock, set prog_en=1, keys 5,6,`#` → OPEN with the code still 1234. Keys 5,6,7 then prog_en dropped → code unchanged.
- Assert reset_n=0 mid-PROGRAM after keys 7,7 → immediate LOCKED pattern, unlocked=0. After release, 1,2,3,4,`#` unlocks.
